des_iter_core: RTL and testbench
================================

// Module: des_iter_core
// PURPOSE
//   Iterative DES engine with run-time encrypt/decrypt select and a valid/ready handshake on input and output.
//   Computes ROUNDS_PER_CYCLE rounds per clock, so area and latency trade off through one parameter.
//   Successor to the fixed-latency lab_7_top datapath; it sits between the key/plaintext source and the result sink.
//   Reuses the existing combinational des_round (f-function + half swap) and the IP/FP/PC-1/PC-2 permutation logic.
// PARAMETERS
//   ROUNDS_PER_CYCLE  1  rounds per clock; legal values 1,2,4,8,16; any other value is a $error at elaboration
//   CHECK_PARITY      0  1 = flag keys whose bytes do not all have odd parity
// PORTS
//   clk        in   1   single clock; all state updates on posedge
//   reset      in   1   synchronous, active-high
//   key_in     in   64  DES key incl. parity bits (bit 63 = key bit 1)
//   data_in    in   64  plaintext (encrypt) or ciphertext (decrypt)
//   decrypt    in   1   0 = encrypt, 1 = decrypt; sampled with the block
//   in_valid   in   1   key_in/data_in/decrypt valid
//   in_ready   out  1   core can accept a block
//   data_out   out  64  result
//   out_valid  out  1   data_out valid
//   out_ready  in   1   sink accepts data_out
//   busy       out  1   block in flight (RUN or DONE)
//   parity_err out  1   key parity fault for the block on data_out; qualified by out_valid
// BEHAVIOUR
//   Reset: state=IDLE; data_out=0, out_valid=0, busy=0, parity_err=0, in_ready=1 on the cycle after reset deasserts.
//   Reset during RUN/DONE aborts the block and applies all reset values at that edge. No partial result is emitted.
//   FSM IDLE -> RUN -> DONE -> IDLE:
//   - IDLE: in_ready=1. A transfer occurs when in_valid&&in_ready at a posedge. At that edge the core:
//     - latches IP(data_in), PC-1(key_in) into C/D, decrypt, and parity status;
//     - sets rnd=0 and goes to RUN.
//   - RUN: in_ready=0, busy=1. Each cycle applies ROUNDS_PER_CYCLE chained rounds; rnd+=ROUNDS_PER_CYCLE.
//     - Encrypt: C/D rotate left 1 (rounds 1,2,9,16) or 2 (others) before PC-2.
//     - Decrypt: round 1 uses unrotated C/D; later rounds rotate right by the encrypt shift of the previous round.
//       This yields K16..K1.
//     - The cycle that completes round 16 registers FP(R16,L16) (halves swapped) into data_out, sets out_valid=1,
//       and goes to DONE.
//     - rnd is 5 bits and never exceeds 16; no wrap.
//   - DONE: out_valid=1. data_out and parity_err stay stable until out_valid&&out_ready at a posedge.
//     That edge clears out_valid and returns to IDLE. Back-pressure may last indefinitely.
//   Latency: N=16/ROUNDS_PER_CYCLE. For an accept at edge T, out_valid is 1 after edge T+N.
//     Throughput is one block per N+2 cycles with out_ready tied high.
//   in_valid while in_ready=0 is ignored; the source must hold it. out_ready while out_valid=0 is ignored.
//   decrypt and key_in changes during RUN have no effect on the block in flight.
//   CHECK_PARITY=1: parity_err=1 if any key_in byte has even popcount. Encryption still completes normally.
//   CHECK_PARITY=0: parity_err is held 0.
// TESTING
//   1. ENC, RPC=1: K=133457799BBCDFF1, P=0123456789ABCDEF -> data_out=85E813540F0AB405.
//      out_valid rises exactly 16 edges after accept; parity_err=0.
//   2. DEC, RPC=1: same K, C=85E813540F0AB405 -> 0123456789ABCDEF.
//      K=0, C=8CA64DE9C1B123A7 -> 0000000000000000.
//   3. Sweep RPC=2,4,8,16 with vectors 1 and 2 -> identical results.
//      Latency 8/4/2/1 edges; scoreboard driven from a vector file with out_ready random.
//   4. Back-pressure: hold out_ready=0 for 20 cycles in DONE -> data_out stable, in_ready=0.
//      A pulsed in_valid is not accepted; the next block is accepted only after the handshake.
//   5. Reset asserted mid-RUN (after 5 rounds) -> all outputs 0 and in_ready=1 after deassert.
//      A new vector then completes correctly.
//   6. CHECK_PARITY=1, K=0000000000000000, P=0 -> data_out=8CA64DE9C1B123A7 with parity_err=1.
//      K=133457799BBCDFF1 -> parity_err=0.

Source files
------------

// File: rtl/des_iter_core.sv
// Iterative DES engine, encrypt/decrypt, valid/ready in and out.
// ROUNDS_PER_CYCLE rounds are chained per clock (16/RPC cycles/block).
module des_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit CHECK_PARITY     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] key_in,
  input  logic [63:0] data_in,
  input  logic        decrypt,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        parity_err
);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
      ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8 &&
      ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
    $error("des_iter_core: ROUNDS_PER_CYCLE must be 1,2,4,8,16");
  end

  localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32};

  localparam int SB [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
    return o;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
    return o;
  endfunction

  function automatic logic [47:0] e_f(input logic [31:0] x);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = x[32-E_T[i]];
    return o;
  endfunction

  function automatic logic [31:0] p_f(input logic [31:0] x);
    logic [31:0] o;
    for (int i = 0; i < 32; i++) o[31-i] = x[32-P_T[i]];
    return o;
  endfunction

  function automatic logic [55:0] pc1_f(input logic [63:0] x);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55-i] = x[64-PC1_T[i]];
    return o;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] x);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = x[56-PC2_T[i]];
    return o;
  endfunction

  // first 6-bit group feeds S1; row = outer bits, column = inner four
  function automatic logic [31:0] sbox_f(input logic [47:0] x);
    logic [31:0] o;
    logic [5:0]  b;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      b = x[47-6*i -: 6];
      o[31-4*i -: 4] = 4'(SB[i][{b[5], b[0], b[4:1]}]);
    end
    return o;
  endfunction

  function automatic logic [27:0] rol28(
    input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] ror28(
    input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  // odd parity expected on every byte of the key
  function automatic logic par_bad_f(input logic [63:0] k);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 8; i++) b = b | ~(^k[8*i +: 8]);
    return b;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic [4:0]  rnd_q;
  logic        dec_q;
  logic        par_q;
  logic [63:0] data_q;

  logic [31:0] l_v, r_v, t_v, f_v;
  logic [27:0] c_v, d_v;
  logic [4:0]  rn;
  logic [1:0]  sh;
  logic        last;

  assign last = (rnd_q + STEP) == 5'd16;

  // chained rounds for one clock; decrypt walks the key schedule backward
  always_comb begin
    l_v = l_q;
    r_v = r_q;
    c_v = c_q;
    d_v = d_q;
    t_v = '0;
    f_v = '0;
    rn  = rnd_q;
    sh  = 2'd0;
    for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      rn = rnd_q + 5'(k);
      if (dec_q) begin
        if (rn == 5'd0)
          sh = 2'd0;
        else if (rn == 5'd1 || rn == 5'd8 || rn == 5'd15)
          sh = 2'd1;
        else
          sh = 2'd2;
        c_v = ror28(c_v, sh);
        d_v = ror28(d_v, sh);
      end else begin
        if (rn == 5'd0 || rn == 5'd1 ||
            rn == 5'd8 || rn == 5'd15)
          sh = 2'd1;
        else
          sh = 2'd2;
        c_v = rol28(c_v, sh);
        d_v = rol28(d_v, sh);
      end
      f_v = p_f(sbox_f(e_f(r_v) ^ pc2_f({c_v, d_v})));
      t_v = l_v ^ f_v;
      l_v = r_v;
      r_v = t_v;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state: accept, iterate, hold result until taken
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath: load on accept, update per cycle, capture final block
  always_ff @(posedge clk) begin
    if (reset) begin
      l_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      rnd_q  <= '0;
      dec_q  <= 1'b0;
      par_q  <= 1'b0;
      data_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          {l_q, r_q} <= ip_f(data_in);
          {c_q, d_q} <= pc1_f(key_in);
          dec_q      <= decrypt;
          par_q      <= CHECK_PARITY & par_bad_f(key_in);
          rnd_q      <= '0;
        end
        RUN: begin
          l_q   <= l_v;
          r_q   <= r_v;
          c_q   <= c_v;
          d_q   <= d_v;
          rnd_q <= rnd_q + STEP;
          if (last) data_q <= fp_f({r_v, l_v});
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign data_out   = data_q;
  assign parity_err = par_q;

endmodule

// File: tb/tb_des_iter_core.sv
// Bench for des_iter_core: five instances (RPC 1..16) share stimulus.
// Directed DES vectors, latency, back-pressure and mid-run reset.
module tb_des_iter_core;

  localparam int NDUT = 5;
  localparam int RPC_T [NDUT] = '{1, 2, 4, 8, 16};
  localparam bit CP_T  [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  logic        tb_clk = 1'b0;
  logic        reset;
  logic [63:0] key_in, data_in;
  logic        decrypt, in_valid, out_ready;

  logic        ir [NDUT];
  logic        ov [NDUT];
  logic        bz [NDUT];
  logic        pe [NDUT];
  logic [63:0] dout [NDUT];

  always #5 tb_clk = ~tb_clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    des_iter_core #(
      .ROUNDS_PER_CYCLE(RPC_T[g]),
      .CHECK_PARITY    (CP_T[g])
    ) u_dut (
      .clk       (tb_clk),
      .reset     (reset),
      .key_in    (key_in),
      .data_in   (data_in),
      .decrypt   (decrypt),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .data_out  (dout[g]),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .busy      (bz[g]),
      .parity_err(pe[g])
    );
  end

  typedef struct packed {
    logic [63:0] key;
    logic [63:0] din;
    logic        dec;
    logic [63:0] exp;
    logic        par;
  } vec_t;

  vec_t vt [4];
  int   n_tot  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm,
                     input logic [79:0] act,
                     input logic [79:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk_status(input string nm);
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("%s[%0d]", nm, i),
          {12'd0, dout[i], ov[i], bz[i], pe[i], ir[i]},
          {12'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int          lat  [NDUT];
    logic [63:0] gd   [NDUT];
    logic        gp   [NDUT];
    bit          seen [NDUT];
    logic [4:0]  m;
    for (int i = 0; i < NDUT; i++) begin
      lat[i] = 0; gd[i] = '0; gp[i] = 1'b0; seen[i] = 1'b0;
    end
    @(negedge tb_clk);
    for (int i = 0; i < NDUT; i++) m[i] = ir[i];
    chk({nm, "_idle"}, 80'(m), 80'h1f);
    key_in = v.key; data_in = v.din; decrypt = v.dec;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge tb_clk);
    in_valid = 1'b0;
    key_in   = ~v.key;
    decrypt  = ~v.dec;
    data_in  = {$urandom, $urandom};
    for (int i = 0; i < NDUT; i++) m[i] = bz[i] & ~ir[i];
    chk({nm, "_busy"}, 80'(m), 80'h1f);
    for (int e = 1; e <= 20; e++) begin
      @(negedge tb_clk);
      for (int i = 0; i < NDUT; i++)
        if (!seen[i] && ov[i]) begin
          seen[i] = 1'b1; lat[i] = e; gd[i] = dout[i]; gp[i] = pe[i];
        end
    end
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("%s_lat[%0d]", nm, i),
          80'(lat[i]), 80'(16 / RPC_T[i]));
      chk($sformatf("%s_data[%0d]", nm, i), 80'(gd[i]), 80'(v.exp));
      chk($sformatf("%s_par[%0d]", nm, i),
          80'(gp[i]), 80'(v.par & CP_T[i]));
    end
  endtask

  initial begin
    int   w;
    logic ok;
    vt[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0,
              64'h85E813540F0AB405, 1'b0};
    vt[1] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1,
              64'h0123456789ABCDEF, 1'b0};
    vt[2] = '{64'h0, 64'h8CA64DE9C1B123A7, 1'b1, 64'h0, 1'b1};
    vt[3] = '{64'h0, 64'h0, 1'b0, 64'h8CA64DE9C1B123A7, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    key_in = '0; data_in = '0; decrypt = 1'b0;
    repeat (3) @(negedge tb_clk);
    reset = 1'b0;
    chk_status("reset");

    for (int k = 0; k < 4; k++) run_vec(vt[k], $sformatf("v%0d", k));

    // back-pressure: every instance parks in DONE
    @(negedge tb_clk);
    key_in = vt[0].key; data_in = vt[0].din; decrypt = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge tb_clk);
    in_valid = 1'b0;
    w = 0;
    while (!ov[0] && w < 40) begin
      @(negedge tb_clk);
      w++;
    end
    chk("bp_lat", 80'(w), 80'd16);
    for (int c = 0; c < 20; c++) begin
      ok = 1'b1;
      for (int i = 0; i < NDUT; i++)
        if (dout[i] !== vt[0].exp || ir[i] !== 1'b0 || ov[i] !== 1'b1)
          ok = 1'b0;
      chk($sformatf("bp_hold%0d", c), 80'(ok), 80'd1);
      in_valid = (c == 10);
      if (c == 10) begin
        key_in = '0; data_in = '0; decrypt = 1'b1;
      end
      @(negedge tb_clk);
    end
    out_ready = 1'b1;
    @(negedge tb_clk);
    ok = 1'b1;
    for (int i = 0; i < NDUT; i++)
      if (ov[i] !== 1'b0 || ir[i] !== 1'b1 || bz[i] !== 1'b0) ok = 1'b0;
    chk("bp_release", 80'(ok), 80'd1);
    run_vec(vt[1], "bp_next");

    // reset after five rounds of the RPC=1 instance
    @(negedge tb_clk);
    key_in = vt[3].key; data_in = vt[3].din; decrypt = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge tb_clk);
    in_valid = 1'b0;
    repeat (5) @(negedge tb_clk);
    chk("rst_midrun", 80'(bz[0]), 80'd1);
    reset = 1'b1;
    @(negedge tb_clk);
    reset = 1'b0;
    chk_status("rst_abort");
    @(negedge tb_clk);
    chk_status("rst_after");
    run_vec(vt[3], "rst_next");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
